// File: rtl/iob_cfg_loader_pkg.sv
// ============================================================================
// Module : iob_cfg_pkg
// Brief  : Shared states and encodings for the IOB serial configuration loader
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iob_cfg_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_t;

  localparam int IOB_CFG_BITS = 3;

  // TSMUX[1] set means the pad is driven unconditionally, so TS_ON covers 2'b1x
  localparam logic [1:0] TS_OFF  = 2'b00;
  localparam logic [1:0] TS_CTRL = 2'b01;
  localparam logic [1:0] TS_ON   = 2'b10;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;

endpackage

`default_nettype wire

// File: rtl/iob_cfg_loader_if.sv
// ============================================================================
// Module : iob_cfg_loader_if
// Brief  : Serial config input and per-IOB configuration outputs of the loader
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface iob_cfg_loader_if #(
  parameter int NUM_IOB = 8
);
  logic                   CFG_DIN;
  logic                   CFG_VALID;
  logic [2*NUM_IOB-1:0]   TSMUX_BUS;
  logic [NUM_IOB-1:0]     DORREG_BUS;
  logic                   CFG_BUSY;
  logic                   CFG_DONE;
  logic                   CFG_ERR;

  modport master (
    output CFG_DIN, CFG_VALID,
    input  TSMUX_BUS, DORREG_BUS, CFG_BUSY, CFG_DONE, CFG_ERR
  );

  modport slave (
    input  CFG_DIN, CFG_VALID,
    output TSMUX_BUS, DORREG_BUS, CFG_BUSY, CFG_DONE, CFG_ERR
  );
endinterface

`default_nettype wire

// File: rtl/iob_cfg_loader_sync_det.sv
// ============================================================================
// Module : iob_cfg_sync_det
// Brief  : Sync-word hunter; shift register plus comparator, 1-cycle hit pulse
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iob_cfg_sync_det
  import iob_cfg_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  shift_en,
  input  wire  din,
  output logic hit
);

  // The 16-bit window is the 15 stored bits plus the live input bit
  logic [14:0] shreg_q;
  logic [14:0] shreg_d;
  logic [15:0] window;

  always_comb begin
    window  = {shreg_q, din};
    shreg_d = shreg_q;
    if (shift_en) begin
      shreg_d = window[14:0];
    end
    hit = shift_en && (window == SYNC_WORD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_cfg_loader.sv
// ============================================================================
// Module : iob_cfg_loader
// Brief  : Serial IOB config writer; sync hunt, payload shadow, atomic commit.
//          Optional parity check stage enabled by IOB_CFG_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iob_cfg_loader
  import iob_cfg_pkg::*;
#(
  parameter int          NUM_IOB   = 8,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  wire               CFGCLK,
  input  wire               RST,
  iob_cfg_loader_if.slave   cfg_if
);

  localparam int PAY_W = IOB_CFG_BITS * NUM_IOB;
  localparam int CNT_W = $clog2(PAY_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAY_W - 1);

  cfg_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAY_W-1:0]     shadow_q, shadow_d;
  logic [2*NUM_IOB-1:0] tsmux_q, tsmux_d;
  logic [NUM_IOB-1:0]   dorreg_q, dorreg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 sync_hit;
  logic [2*NUM_IOB-1:0] tsmux_map;
  logic [NUM_IOB-1:0]   dorreg_map;

  iob_cfg_sync_det #(.SYNC_WORD(SYNC_WORD)) u_sync_det (
    .clk      (CFGCLK),
    .rst      (RST),
    .shift_en (cfg_if.CFG_VALID && (state_q == HUNT)),
    .din      (cfg_if.CFG_DIN),
    .hit      (sync_hit)
  );

  // IOB0 arrives first, so it ends up in the top bits of the shadow
  for (genvar i = 0; i < NUM_IOB; i++) begin : g_iob
    assign tsmux_map[2*i+1] = shadow_q[PAY_W-1-3*i];
    assign tsmux_map[2*i]   = shadow_q[PAY_W-2-3*i];
    assign dorreg_map[i]    = shadow_q[PAY_W-3-3*i];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tsmux_d  = tsmux_q;
    dorreg_d = dorreg_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      HUNT: begin
        if (sync_hit) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_if.CFG_VALID) begin
          shadow_d = {shadow_q[PAY_W-2:0], cfg_if.CFG_DIN};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
`ifdef IOB_CFG_PARITY_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end
        end
      end
`ifdef IOB_CFG_PARITY_EN
      CHECK: begin
        if (cfg_if.CFG_VALID) begin
          if (^{shadow_q, cfg_if.CFG_DIN}) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = COMMIT;
          end
        end
      end
`endif
      COMMIT: begin
        tsmux_d  = tsmux_map;
        dorreg_d = dorreg_map;
        done_d   = 1'b1;
        state_d  = HUNT;
      end
      default: state_d = HUNT;
    endcase
    busy_d = (state_d == LOAD) || (state_d == CHECK);
  end

  // Without the parity stage nothing sets err_q, so CFG_ERR stays 0
  always_ff @(posedge CFGCLK or posedge RST) begin
    if (RST) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shadow_q <= '0;
      tsmux_q  <= '0;
      dorreg_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tsmux_q  <= tsmux_d;
      dorreg_q <= dorreg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg_if.TSMUX_BUS  = tsmux_q;
  assign cfg_if.DORREG_BUS = dorreg_q;
  assign cfg_if.CFG_BUSY   = busy_q;
  assign cfg_if.CFG_DONE   = done_q;
  assign cfg_if.CFG_ERR    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_cfg_loader.sv
// ============================================================================
// Module : tb_iob_cfg_loader
// Brief  : Directed frames for iob_cfg_loader with a queue-based frame checker
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iob_cfg_loader;

  localparam int N = 8;

  typedef struct packed {
    logic [2*N-1:0] ts;
    logic [N-1:0]   dor;
    logic           done;
    logic           err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iob_cfg_loader_if #(.NUM_IOB(N)) cfg_if ();

  iob_cfg_loader #(.NUM_IOB(N), .SYNC_WORD(16'hA5C3)) dut (
    .CFGCLK (clk),
    .RST    (rst),
    .cfg_if (cfg_if)
  );

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   evt_cyc  = -1;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [2*N-1:0] ts, input logic [N-1:0] dor,
                              input logic done, input logic err);
    exp_t e;
    e.ts = ts; e.dor = dor; e.done = done; e.err = err;
    return e;
  endfunction

  // A frame ends when DONE or ERR rises; compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if ((cfg_if.CFG_DONE && !prev_done) || (cfg_if.CFG_ERR && !prev_err)) begin
        evt_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_end: got done=%0b err=%0b, expected no event",
                   cfg_if.CFG_DONE, cfg_if.CFG_ERR);
        end else begin
          e = sb_q.pop_front();
          check("frame_tsmux",  32'(cfg_if.TSMUX_BUS),  32'(e.ts));
          check("frame_dorreg", 32'(cfg_if.DORREG_BUS), 32'(e.dor));
          check("frame_done",   32'(cfg_if.CFG_DONE),   32'(e.done));
          check("frame_err",    32'(cfg_if.CFG_ERR),    32'(e.err));
        end
      end
      prev_done = cfg_if.CFG_DONE;
      prev_err  = cfg_if.CFG_ERR;
    end
  end

  // MSB first; with gap set, an invalid cycle carrying the inverted bit precedes each bit
  task automatic send(input logic [63:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap) begin
        @(negedge clk);
        cfg_if.CFG_VALID = 1'b0;
        cfg_if.CFG_DIN   = ~v[i];
      end
      @(negedge clk);
      cfg_if.CFG_VALID = 1'b1;
      cfg_if.CFG_DIN   = v[i];
    end
  endtask

  task automatic idle(input int n, input logic [63:0] pattern);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_if.CFG_VALID = 1'b0;
      cfg_if.CFG_DIN   = pattern[i % 64];
    end
  endtask

  task automatic frame(input logic [23:0] pay, input bit bad_par, input bit gap, input exp_t e);
    int   last;
    logic par;
    par = (^pay) ^ bad_par;
    sb_q.push_back(e);
    send(64'hA5C3, 16, gap);
    send({40'd0, pay}, 24, gap);
`ifdef IOB_CFG_PARITY_EN
    send({63'd0, par}, 1, gap);
`endif
    @(negedge clk);
    cfg_if.CFG_VALID = 1'b0;
    last = cyc;
    if (e.done) begin
      check("no_early_commit", 32'(cfg_if.CFG_DONE), 32'd0);
    end
    idle(2, 64'd0);
    check("frame_latency", 32'(evt_cyc), 32'(last + (e.err ? 0 : 1)));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("busy_after_frame", 32'(cfg_if.CFG_BUSY), 32'd0);
  endtask

  initial begin
    cfg_if.CFG_VALID = 1'b0;
    cfg_if.CFG_DIN   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Test 1: a sync pattern on DIN while VALID stays low must do nothing
    idle(48, {16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3});
    check("idle_tsmux",  32'(cfg_if.TSMUX_BUS),  32'd0);
    check("idle_dorreg", 32'(cfg_if.DORREG_BUS), 32'd0);
    check("idle_done",   32'(cfg_if.CFG_DONE),   32'd0);
    check("idle_err",    32'(cfg_if.CFG_ERR),    32'd0);
    check("idle_busy",   32'(cfg_if.CFG_BUSY),   32'd0);

    // Test 2: payload 011_100 then zeros -> IOB0 ts=01 dor=1, IOB1 ts=10 dor=0
    frame(24'h700000, 1'b0, 1'b0, mk(16'h0009, 8'h01, 1'b1, 1'b0));

`ifdef IOB_CFG_PARITY_EN
    // Test 3: wrong parity -> ERR, outputs hold
    frame(24'h700000, 1'b1, 1'b0, mk(16'h0009, 8'h01, 1'b0, 1'b1));
    check("err_hold_tsmux", 32'(cfg_if.TSMUX_BUS), 32'h0009);
`endif

    // Test 5: garbage byte before sync, payload contains the sync word itself
    send(64'hA5, 8, 1'b0);
    frame(24'hA5C300, 1'b0, 1'b0, mk(16'h0892, 8'h17, 1'b1, 1'b0));

    // Test 4: test 2 frame with VALID toggling every cycle
    frame(24'h700000, 1'b0, 1'b1, mk(16'h0009, 8'h01, 1'b1, 1'b0));

    // Test 6: reset after three payload bits, then a clean frame
    send(64'hA5C3, 16, 1'b0);
    send(64'h5, 3, 1'b0);
    @(negedge clk);
    cfg_if.CFG_VALID = 1'b0;
    check("midframe_busy", 32'(cfg_if.CFG_BUSY), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_tsmux",  32'(cfg_if.TSMUX_BUS),  32'd0);
    check("rst_dorreg", 32'(cfg_if.DORREG_BUS), 32'd0);
    check("rst_done",   32'(cfg_if.CFG_DONE),   32'd0);
    check("rst_busy",   32'(cfg_if.CFG_BUSY),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(24'hA5C300, 1'b0, 1'b0, mk(16'h0892, 8'h17, 1'b1, 1'b0));

    idle(4, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
